showdown_ctrl: RTL and testbench

- Sequences a single shared combinational hand evaluator (42-bit card bus in, 24-bit hand code out) between the two players at showdown.
- Latches the board and both hole pairs, validates them, and presents player 1's then player 2's 7-card set to the evaluator, each for a fixed settle window.
- Captures both hand codes, compares them and reports the winner.
- Sits between the game-flow FSM (which issues start) and the evaluator instance.

---
 rtl/poker_pkg.sv | 57 +++++
 rtl/hand_compare.sv | 57 +++++
 rtl/showdown_ctrl.sv | 174 +++++++++++++++++
 tb/tb_showdown_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_pkg.sv
// ============================================================================
// poker_pkg : shared card, category and winner encodings for the poker core
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package poker_pkg;

    localparam int CARD_W    = 6;
    localparam int NUM_CARDS = 9;

    localparam logic [3:0] TWO   = 4'd2;
    localparam logic [3:0] THREE = 4'd3;
    localparam logic [3:0] FOUR  = 4'd4;
    localparam logic [3:0] FIVE  = 4'd5;
    localparam logic [3:0] SIX   = 4'd6;
    localparam logic [3:0] SEVEN = 4'd7;
    localparam logic [3:0] EIGHT = 4'd8;
    localparam logic [3:0] NINE  = 4'd9;
    localparam logic [3:0] TEN   = 4'd10;
    localparam logic [3:0] JACK  = 4'd11;
    localparam logic [3:0] QUEEN = 4'd12;
    localparam logic [3:0] KING  = 4'd13;
    localparam logic [3:0] ACE   = 4'd14;

    localparam logic [1:0] SUIT_C = 2'b00;
    localparam logic [1:0] SUIT_H = 2'b01;
    localparam logic [1:0] SUIT_S = 2'b10;
    localparam logic [1:0] SUIT_D = 2'b11;

    localparam logic [3:0] HIGHCARD      = 4'd0;
    localparam logic [3:0] PAIR          = 4'd1;
    localparam logic [3:0] TWOPAIR       = 4'd2;
    localparam logic [3:0] TRIPS         = 4'd3;
    localparam logic [3:0] STRAIGHT      = 4'd4;
    localparam logic [3:0] FLUSH         = 4'd5;
    localparam logic [3:0] FULLHOUSE     = 4'd6;
    localparam logic [3:0] QUADS         = 4'd7;
    localparam logic [3:0] STRAIGHTFLUSH = 4'd8;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    function automatic logic card_rank_ok(input card_t c);
        return (c.rank >= TWO) && (c.rank <= ACE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hand_compare.sv
// ============================================================================
// hand_compare : decides the winner of two evaluated hands, hole cards as tiebreak
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module hand_compare
    import poker_pkg::*;
(
    input  logic [23:0] i_hand_a,
    input  logic [23:0] i_hand_b,
    input  logic [11:0] i_hole_a,
    input  logic [11:0] i_hole_b,
    output logic [1:0]  o_winner
);

    card_t      w_a0, w_a1, w_b0, w_b1;
    logic [3:0] w_hi_a, w_lo_a, w_hi_b, w_lo_b;
    logic [3:0] w_cat_a, w_cat_b, w_pri_a, w_pri_b;
    logic       w_unused_bits;

    assign w_a0 = i_hole_a[5:0];
    assign w_a1 = i_hole_a[11:6];
    assign w_b0 = i_hole_b[5:0];
    assign w_b1 = i_hole_b[11:6];

    assign w_cat_a = i_hand_a[23:20];
    assign w_cat_b = i_hand_b[23:20];
    assign w_pri_a = i_hand_a[19:16];
    assign w_pri_b = i_hand_b[19:16];

    // Only category, primary rank and hole ranks take part in the decision
    assign w_unused_bits = ^{i_hand_a[15:0], i_hand_b[15:0],
                             w_a0.suit, w_a1.suit, w_b0.suit, w_b1.suit};

    always_comb begin
        w_hi_a = (w_a0.rank > w_a1.rank) ? w_a0.rank : w_a1.rank;
        w_lo_a = (w_a0.rank > w_a1.rank) ? w_a1.rank : w_a0.rank;
        w_hi_b = (w_b0.rank > w_b1.rank) ? w_b0.rank : w_b1.rank;
        w_lo_b = (w_b0.rank > w_b1.rank) ? w_b1.rank : w_b0.rank;
    end

    always_comb begin
        o_winner = WIN_TIE;
        if (w_cat_a != w_cat_b)
            o_winner = (w_cat_a > w_cat_b) ? WIN_P1 : WIN_P2;
        else if (w_pri_a != w_pri_b)
            o_winner = (w_pri_a > w_pri_b) ? WIN_P1 : WIN_P2;
        else if (w_hi_a != w_hi_b)
            o_winner = (w_hi_a > w_hi_b) ? WIN_P1 : WIN_P2;
        else if (w_lo_a != w_lo_b)
            o_winner = (w_lo_a > w_lo_b) ? WIN_P1 : WIN_P2;
    end

endmodule

`default_nettype wire

// File: rtl/showdown_ctrl.sv
// ============================================================================
// showdown_ctrl : time-shares one hand evaluator between both players at showdown
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module showdown_ctrl
    import poker_pkg::*;
#(
    parameter int EVAL_LAT = 2,
    parameter int CNT_W    = 3
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] board,
    input  logic [11:0] p1_hole,
    input  logic [11:0] p2_hole,
    output logic [41:0] eval_cards,
    input  logic [23:0] eval_result,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  winner,
    output logic [23:0] p1_hand,
    output logic [23:0] p2_hand
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_EVAL_P1 = 3'd2;
    localparam logic [2:0] S_EVAL_P2 = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(EVAL_LAT - 1);

    logic [2:0]       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [29:0]      r_board;
    logic [11:0]      r_p1, r_p2;
    logic [41:0]      r_eval_cards;
    logic             r_error;
    logic [1:0]       r_winner;
    logic [23:0]      r_p1_hand, r_p2_hand;

    logic             w_accept;
    logic             w_cnt_last;
    logic             w_invalid;
    logic [1:0]       w_cmp_winner;
    logic [29:0]      w_board_src;
    logic [11:0]      w_p1_src, w_p2_src;
    card_t            w_cards [NUM_CARDS];

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // Card-set validation over the latched copy: rank range plus all 36 pairs
    always_comb begin
        for (int i = 0; i < 5; i++)
            w_cards[i] = r_board[CARD_W*i +: CARD_W];
        w_cards[5] = r_p1[5:0];
        w_cards[6] = r_p1[11:6];
        w_cards[7] = r_p2[5:0];
        w_cards[8] = r_p2[11:6];

        w_invalid = 1'b0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (!card_rank_ok(w_cards[i]))
                w_invalid = 1'b1;
            for (int j = i + 1; j < NUM_CARDS; j++) begin
                if (w_cards[i] == w_cards[j])
                    w_invalid = 1'b1;
            end
        end
    end

    hand_compare u_hand_compare (
        .i_hand_a (r_p1_hand),
        .i_hand_b (r_p2_hand),
        .i_hole_a (r_p1),
        .i_hole_b (r_p2),
        .o_winner (w_cmp_winner)
    );

    // An invalid set still passes through COMPARE so its done pulse lands
    // two cycles after start; COMPARE forces the winner to none in that case.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_CHECK;
            S_CHECK:   w_next_state = w_invalid ? S_COMPARE : S_EVAL_P1;
            S_EVAL_P1: if (w_cnt_last) w_next_state = S_EVAL_P2;
            S_EVAL_P2: if (w_cnt_last) w_next_state = S_COMPARE;
            S_COMPARE: w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // The evaluator bus is registered from the next state, so it must see the
    // cards being latched on an accepted start rather than the old copy.
    assign w_board_src = w_accept ? board   : r_board;
    assign w_p1_src    = w_accept ? p1_hole : r_p1;
    assign w_p2_src    = w_accept ? p2_hole : r_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_board      <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_eval_cards <= '0;
            r_error      <= 1'b0;
            r_winner     <= WIN_NONE;
            r_p1_hand    <= '0;
            r_p2_hand    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_eval_cards <= {w_board_src,
                             (w_next_state == S_EVAL_P2) ? w_p2_src : w_p1_src};
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_board   <= board;
                        r_p1      <= p1_hole;
                        r_p2      <= p2_hole;
                        r_error   <= 1'b0;
                        r_winner  <= WIN_NONE;
                        r_p1_hand <= '0;
                        r_p2_hand <= '0;
                    end
                end
                S_CHECK: begin
                    r_error <= w_invalid;
                    r_cnt   <= '0;
                end
                S_EVAL_P1: begin
                    if (w_cnt_last) begin
                        r_p1_hand <= eval_result;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EVAL_P2: begin
                    if (w_cnt_last) begin
                        r_p2_hand <= eval_result;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_COMPARE: begin
                    r_winner <= r_error ? WIN_NONE : w_cmp_winner;
                end
                default: begin
                end
            endcase
        end
    end

    assign eval_cards = r_eval_cards;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign error      = r_error;
    assign winner     = r_winner;
    assign p1_hand    = r_p1_hand;
    assign p2_hand    = r_p2_hand;

endmodule

`default_nettype wire

// File: tb/tb_showdown_ctrl.sv
// ============================================================================
// tb_showdown_ctrl : scoreboard bench for showdown_ctrl with a behavioural evaluator
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_showdown_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [29:0] board;
    logic [11:0] p1, p2;

    logic [41:0] a_eval_cards, b_eval_cards;
    logic [23:0] a_eval_result, b_eval_result;
    logic        a_busy, a_done, a_error, b_busy, b_done, b_error;
    logic [1:0]  a_winner, b_winner;
    logic [23:0] a_p1_hand, a_p2_hand, b_p1_hand, b_p2_hand;

    typedef struct {
        logic        err;
        logic [1:0]  win;
        logic [23:0] p1h;
        logic [23:0] p2h;
        int          lat;
        int          p2cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural 7-card evaluator: {category, primary rank, rank mask}
    function automatic logic [3:0] straight_hi(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int h = 14; h >= 6; h--)
            if (r == 4'd0 && m[h] && m[h-1] && m[h-2] && m[h-3] && m[h-4])
                r = 4'(h);
        if (r == 4'd0 && m[14] && m[2] && m[3] && m[4] && m[5])
            r = 4'd5;
        return r;
    endfunction

    function automatic logic [23:0] eval7(input logic [41:0] c);
        int rc[16];
        int sc[4];
        logic [15:0] m;
        logic [15:0] sm[4];
        logic [5:0]  cd;
        logic [3:0]  cat, pr;
        int quad, trip, pairs, phi, fs, hi;
        m = '0;
        for (int i = 0; i < 16; i++) rc[i] = 0;
        for (int s = 0; s < 4; s++) begin sc[s] = 0; sm[s] = '0; end
        for (int i = 0; i < 7; i++) begin
            cd = c[6*i +: 6];
            rc[cd[3:0]]++;
            sc[cd[5:4]]++;
            m[cd[3:0]] = 1'b1;
            sm[cd[5:4]][cd[3:0]] = 1'b1;
        end
        quad = 0; trip = 0; pairs = 0; phi = 0; fs = -1; hi = 0;
        for (int r = 2; r <= 14; r++) begin
            if (rc[r] == 4) quad = r;
            if (rc[r] == 3) trip = r;
            if (rc[r] >= 2) pairs++;
            if (rc[r] == 2) phi = r;
            if (rc[r] != 0) hi = r;
        end
        for (int s = 0; s < 4; s++) if (sc[s] >= 5) fs = s;
        if (fs >= 0 && straight_hi(sm[fs]) != 4'd0) begin
            cat = 4'd8; pr = straight_hi(sm[fs]);
        end else if (quad != 0) begin
            cat = 4'd7; pr = 4'(quad);
        end else if (trip != 0 && pairs >= 2) begin
            cat = 4'd6; pr = 4'(trip);
        end else if (fs >= 0) begin
            cat = 4'd5; pr = 4'd0;
            for (int r = 2; r <= 14; r++) if (sm[fs][r]) pr = 4'(r);
        end else if (straight_hi(m) != 4'd0) begin
            cat = 4'd4; pr = straight_hi(m);
        end else if (trip != 0) begin
            cat = 4'd3; pr = 4'(trip);
        end else if (pairs >= 2) begin
            cat = 4'd2; pr = 4'(phi);
        end else if (pairs == 1) begin
            cat = 4'd1; pr = 4'(phi);
        end else begin
            cat = 4'd0; pr = 4'(hi);
        end
        return {cat, pr, m};
    endfunction

    function automatic logic [5:0] cd(input logic [1:0] s, input logic [3:0] r);
        return {s, r};
    endfunction

    assign a_eval_result = eval7(a_eval_cards);
    assign b_eval_result = eval7(b_eval_cards);

    showdown_ctrl u_dut_a (
        .clk (clk), .rst_n (rst_n), .start (start_a),
        .board (board), .p1_hole (p1), .p2_hole (p2),
        .eval_cards (a_eval_cards), .eval_result (a_eval_result),
        .busy (a_busy), .done (a_done), .error (a_error), .winner (a_winner),
        .p1_hand (a_p1_hand), .p2_hand (a_p2_hand)
    );

    showdown_ctrl #(.EVAL_LAT (4), .CNT_W (3)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .start (start_b),
        .board (board), .p1_hole (p1), .p2_hole (p2),
        .eval_cards (b_eval_cards), .eval_result (b_eval_result),
        .busy (b_busy), .done (b_done), .error (b_error), .winner (b_winner),
        .p1_hand (b_p1_hand), .p2_hand (b_p2_hand)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_case(input string nm, input bit sel, input bit hold,
                            input logic [29:0] b, input logic [11:0] h1, input logic [11:0] h2,
                            input bit e_err, input logic [1:0] e_win,
                            input logic [3:0] c1, input logic [3:0] c2,
                            input logic [3:0] r1, input logic [3:0] r2);
        exp_t x, got;
        int   cyc, p2c, blow, extra;
        bit   seen;
        x.err   = e_err;
        x.win   = e_win;
        x.p1h   = e_err ? 24'd0 : eval7({b, h1});
        x.p2h   = e_err ? 24'd0 : eval7({b, h2});
        x.lat   = e_err ? 2 : (sel ? 10 : 6);
        x.p2cyc = e_err ? 0 : (sel ? 4 : 2);
        q.push_back(x);

        @(negedge clk);
        board = b; p1 = h1; p2 = h2;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end

        cyc = 0; p2c = 0; blow = 0; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (!(sel ? b_busy : a_busy)) blow++;
            if ((sel ? b_eval_cards : a_eval_cards) == {b, h2}) p2c++;
            seen = sel ? b_done : a_done;
        end
        start_a = 1'b0; start_b = 1'b0;
        chk({nm, ".done_seen"}, 64'(seen), 64'd1);

        got = q.pop_front();
        chk({nm, ".latency"}, 64'(cyc), 64'(got.lat));
        chk({nm, ".error"}, 64'(sel ? b_error : a_error), 64'(got.err));
        chk({nm, ".winner"}, 64'(sel ? b_winner : a_winner), 64'(got.win));
        chk({nm, ".p1_hand"}, 64'(sel ? b_p1_hand : a_p1_hand), 64'(got.p1h));
        chk({nm, ".p2_hand"}, 64'(sel ? b_p2_hand : a_p2_hand), 64'(got.p2h));
        chk({nm, ".p2_cycles"}, 64'(p2c), 64'(got.p2cyc));
        chk({nm, ".busy_gaps"}, 64'(blow), 64'd0);
        if (!e_err) begin
            chk({nm, ".p1_cat"}, 64'((sel ? b_p1_hand : a_p1_hand) >> 20), 64'(c1));
            chk({nm, ".p2_cat"}, 64'((sel ? b_p2_hand : a_p2_hand) >> 20), 64'(c2));
            chk({nm, ".p1_pri"}, 64'((sel ? b_p1_hand[19:16] : a_p1_hand[19:16])), 64'(r1));
            chk({nm, ".p2_pri"}, 64'((sel ? b_p2_hand[19:16] : a_p2_hand[19:16])), 64'(r2));
        end

        extra = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (sel ? b_done : a_done) extra++;
        end
        chk({nm, ".extra_done"}, 64'(extra), 64'd0);
        chk({nm, ".idle_busy"}, 64'(sel ? b_busy : a_busy), 64'd0);
        chk({nm, ".winner_hold"}, 64'(sel ? b_winner : a_winner), 64'(got.win));
        chk({nm, ".error_hold"}, 64'(sel ? b_error : a_error), 64'(got.err));
    endtask

    logic [29:0] bd1, bd2, bd3;
    logic [11:0] h1a, h1b, h2a, h2b, h3a, h3b, hdup, hbad1, hbad15;
    int          ndone;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        board = '0; p1 = '0; p2 = '0;

        bd1  = {cd(2'b00, 4'd2), cd(2'b00, 4'd7), cd(2'b10, 4'd13), cd(2'b01, 4'd14), cd(2'b00, 4'd14)};
        h1a  = {cd(2'b11, 4'd14), cd(2'b10, 4'd14)};
        h1b  = {cd(2'b00, 4'd4),  cd(2'b00, 4'd9)};
        bd2  = {cd(2'b00, 4'd3), cd(2'b11, 4'd5), cd(2'b10, 4'd9), cd(2'b01, 4'd13), cd(2'b00, 4'd13)};
        h2a  = {cd(2'b01, 4'd2),  cd(2'b00, 4'd12)};
        h2b  = {cd(2'b01, 4'd8),  cd(2'b11, 4'd11)};
        bd3  = {cd(2'b00, 4'd14), cd(2'b11, 4'd13), cd(2'b10, 4'd12), cd(2'b01, 4'd11), cd(2'b00, 4'd10)};
        h3a  = {cd(2'b01, 4'd3),  cd(2'b00, 4'd2)};
        h3b  = {cd(2'b10, 4'd3),  cd(2'b11, 4'd2)};
        hdup = {cd(2'b00, 4'd4),  cd(2'b00, 4'd14)};
        hbad1  = {cd(2'b01, 4'd1),  cd(2'b00, 4'd12)};
        hbad15 = {cd(2'b11, 4'd15), cd(2'b11, 4'd9)};

        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy",       64'(a_busy),       64'd0);
        chk("reset.done",       64'(a_done),       64'd0);
        chk("reset.winner",     64'(a_winner),     64'd0);
        chk("reset.eval_cards", 64'(a_eval_cards), 64'd0);
        chk("reset.b_busy",     64'(b_busy),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_case("quads_v_flush", 1'b0, 1'b0, bd1, h1a, h1b, 1'b0, 2'b01, 4'd7, 4'd5, 4'd14, 4'd14);
        run_case("kings_kicker",  1'b0, 1'b0, bd2, h2a, h2b, 1'b0, 2'b01, 4'd1, 4'd1, 4'd13, 4'd13);
        run_case("board_plays",   1'b0, 1'b0, bd3, h3a, h3b, 1'b0, 2'b11, 4'd4, 4'd4, 4'd14, 4'd14);
        run_case("duplicate",     1'b0, 1'b0, bd1, h1a, hdup, 1'b1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        run_case("p2_wins",       1'b0, 1'b0, bd1, h1b, h1a, 1'b0, 2'b10, 4'd5, 4'd7, 4'd14, 4'd14);
        run_case("rank_low",      1'b0, 1'b0, bd2, hbad1, h2b, 1'b1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);
        run_case("start_held",    1'b0, 1'b1, bd2, h2a, h2b, 1'b0, 2'b01, 4'd1, 4'd1, 4'd13, 4'd13);
        run_case("lat4_quads",    1'b1, 1'b0, bd1, h1a, h1b, 1'b0, 2'b01, 4'd7, 4'd5, 4'd14, 4'd14);
        run_case("lat4_rank_hi",  1'b1, 1'b0, bd2, h2a, hbad15, 1'b1, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0);

        // Reset while player 2 is on the evaluator
        @(negedge clk);
        board = bd1; p1 = h1a; p2 = h1b; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.in_p2", 64'(a_eval_cards), 64'({bd1, h1b}));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst.busy",       64'(a_busy),       64'd0);
        chk("midrst.done",       64'(a_done),       64'd0);
        chk("midrst.error",      64'(a_error),      64'd0);
        chk("midrst.winner",     64'(a_winner),     64'd0);
        chk("midrst.p1_hand",    64'(a_p1_hand),    64'd0);
        chk("midrst.p2_hand",    64'(a_p2_hand),    64'd0);
        chk("midrst.eval_cards", 64'(a_eval_cards), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (a_done) ndone++;
        end
        chk("midrst.no_done", 64'(ndone), 64'd0);

        run_case("after_reset",   1'b0, 1'b0, bd3, h3a, h3b, 1'b0, 2'b11, 4'd4, 4'd4, 4'd14, 4'd14);
        chk("scoreboard.empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
